ifmap_read_scheduler: RTL and testbench

IFMAP_READ_SCHEDULER -- requirements
Module: ifmap_read_scheduler

---
 rtl/ifmap_sched_pkg.sv | 15 +
 rtl/ifmap_raddr_counter.sv | 58 +++++
 rtl/ifmap_read_scheduler.sv | 163 ++++++++++++++++
 tb/tb_ifmap_read_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_sched_pkg.sv
// Shared definitions for the ifmap read scheduler.
// Holds the scheduler FSM state encoding and its width constant.
package ifmap_sched_pkg;

  localparam int unsigned SCHED_STATE_W = 3;

  typedef enum logic [SCHED_STATE_W-1:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    SWITCH = 3'd2,
    READ   = 3'd3,
    DONE   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/ifmap_raddr_counter.sv
// Read-address / pass counter for one ping-pong bank.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   clear_i      - zero both counters (new layer configuration)
//   enable_i     - advance one word (a read was issued this cycle)
//   n_i, p_i     - words per bank, read passes per bank (already >= 1)
//   raddr_o      - current word address 0..N-1
//   pass_cnt_o   - current pass 0..P-1
//   last_o       - raddr_o is the final word of a pass
module ifmap_raddr_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] n_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] raddr_o,
  output logic [W-1:0] pass_cnt_o,
  output logic         last_o
);

  logic [W-1:0] raddr_q, raddr_d;
  logic [W-1:0] pass_q, pass_d;

  assign last_o     = (raddr_q == n_i - W'(1));
  assign raddr_o    = raddr_q;
  assign pass_cnt_o = pass_q;

  always_comb begin
    raddr_d = raddr_q;
    pass_d  = pass_q;
    if (clear_i) begin
      raddr_d = '0;
      pass_d  = '0;
    end else if (enable_i) begin
      if (last_o) begin
        // Both counters wrap after the final pass so the next bank starts clean.
        raddr_d = '0;
        pass_d  = (pass_q == p_i - W'(1)) ? '0 : pass_q + W'(1);
      end else begin
        raddr_d = raddr_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raddr_q <= '0;
      pass_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: rtl/ifmap_read_scheduler.sv
// Input-feature-map read scheduler for a ping-pong bank buffer.
// Waits for the write side to fill a bank, switches banks, then reads the
// bank P times (N words per pass), for B banks per layer.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   config_done                    - latch N/B/P (accepted in IDLE/DONE only)
//   config_IC1_IY0_IX0 (N)         - words per bank
//   config_OY1_OX1     (B)         - banks per layer
//   config_OC1         (P)         - read passes per bank
//   write_bank_ready_to_switch     - write side holds a full bank
//   rd_stall                       - consumer cannot accept data
//   ready_to_switch                - one-cycle bank swap pulse
//   start_new_write_bank           - write side may start another bank
//   ren / raddr                    - read strobe and address
//   rdata_vld                      - ren delayed by the buffer read latency
//   sched_busy / sched_done        - active / layer complete
// Optional: define IFMAP_SCHED_PERF_CNT_EN to add perf_stall_cnt, a saturating
// count of READ cycles with rd_stall asserted.
module ifmap_read_scheduler
  import ifmap_sched_pkg::*;
#(
  parameter int unsigned BANK_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_done,
  input  logic [BANK_ADDR_WIDTH-1:0] config_IC1_IY0_IX0,
  input  logic [BANK_ADDR_WIDTH-1:0] config_OY1_OX1,
  input  logic [BANK_ADDR_WIDTH-1:0] config_OC1,
  input  logic                       write_bank_ready_to_switch,
  input  logic                       rd_stall,
  output logic                       ready_to_switch,
  output logic                       start_new_write_bank,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] raddr,
  output logic                       rdata_vld,
  output logic                       sched_busy,
  output logic                       sched_done
`ifdef IFMAP_SCHED_PERF_CNT_EN
  ,
  output logic [BANK_ADDR_WIDTH-1:0] perf_stall_cnt
`endif
);

  localparam int unsigned W = BANK_ADDR_WIDTH;

  sched_state_e state_q, state_d;
  logic [W-1:0] n_q, n_d, b_q, b_d, p_q, p_d;
  logic [W-1:0] bank_cnt_q, bank_cnt_d;
  logic         rvld_q;
  logic         cfg_load;
  logic         addr_last;
  logic [W-1:0] pass_cnt;
  logic         bank_end;

  assign cfg_load = config_done && ((state_q == IDLE) || (state_q == DONE));
  assign bank_end = addr_last && (pass_cnt == p_q - W'(1));

  always_comb begin
    n_d = n_q;
    b_d = b_q;
    p_d = p_q;
    if (cfg_load) begin
      n_d = (config_IC1_IY0_IX0 == '0) ? W'(1) : config_IC1_IY0_IX0;
      b_d = (config_OY1_OX1 == '0)     ? W'(1) : config_OY1_OX1;
      p_d = (config_OC1 == '0)         ? W'(1) : config_OC1;
    end
  end

  always_comb begin
    state_d              = state_q;
    bank_cnt_d           = bank_cnt_q;
    ready_to_switch      = 1'b0;
    start_new_write_bank = 1'b0;
    ren                  = 1'b0;
    sched_busy           = 1'b0;
    sched_done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (config_done) begin
          state_d    = FILL;
          bank_cnt_d = '0;
        end
      end
      FILL: begin
        sched_busy = 1'b1;
        if (write_bank_ready_to_switch) state_d = SWITCH;
      end
      SWITCH: begin
        sched_busy           = 1'b1;
        ready_to_switch      = 1'b1;
        bank_cnt_d           = bank_cnt_q + W'(1);
        start_new_write_bank = (bank_cnt_d < b_q);
        state_d              = READ;
      end
      READ: begin
        sched_busy = 1'b1;
        ren        = !rd_stall;
        if (ren && bank_end) state_d = (bank_cnt_q == b_q) ? DONE : FILL;
      end
      DONE: begin
        sched_done = 1'b1;
        if (config_done) begin
          state_d    = FILL;
          bank_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      bank_cnt_q <= '0;
      rvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      b_q        <= b_d;
      p_q        <= p_d;
      bank_cnt_q <= bank_cnt_d;
      rvld_q     <= ren;
    end
  end

  assign rdata_vld = rvld_q;

  ifmap_raddr_counter #(
    .W (W)
  ) u_raddr_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (cfg_load),
    .enable_i   (ren),
    .n_i        (n_q),
    .p_i        (p_q),
    .raddr_o    (raddr),
    .pass_cnt_o (pass_cnt),
    .last_o     (addr_last)
  );

`ifdef IFMAP_SCHED_PERF_CNT_EN
  logic [W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (cfg_load) perf_d = '0;
    else if ((state_q == READ) && rd_stall && (perf_q != '1)) perf_d = perf_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_ifmap_read_scheduler.sv
module tb_ifmap_read_scheduler;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         config_done;
  logic [W-1:0] cfg_n, cfg_b, cfg_p;
  logic         wr_rdy;
  logic         rd_stall;
  logic         rts, snwb, ren, vld, busy, done;
  logic [W-1:0] raddr;
`ifdef IFMAP_SCHED_PERF_CNT_EN
  logic [W-1:0] perf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifmap_read_scheduler #(.BANK_ADDR_WIDTH(W)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .config_done                (config_done),
    .config_IC1_IY0_IX0         (cfg_n),
    .config_OY1_OX1             (cfg_b),
    .config_OC1                 (cfg_p),
    .write_bank_ready_to_switch (wr_rdy),
    .rd_stall                   (rd_stall),
    .ready_to_switch            (rts),
    .start_new_write_bank       (snwb),
    .ren                        (ren),
    .raddr                      (raddr),
    .rdata_vld                  (vld),
    .sched_busy                 (busy),
    .sched_done                 (done)
`ifdef IFMAP_SCHED_PERF_CNT_EN
    ,
    .perf_stall_cnt             (perf)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; config_done = 1'b0; wr_rdy = 1'b0; rd_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Flags vector order: {ready_to_switch, start_new_write_bank, ren, rdata_vld, busy, done}
  task automatic test_reset();
    logic [5:0] obs;
    @(negedge clk);
    rst_n = 1'b0; config_done = 1'b0; wr_rdy = 1'b0; rd_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    obs = {rts, snwb, ren, vld, busy, done};
    checks++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp %b", obs, 6'b0); end
    checks++;
    if (raddr !== '0) begin errors++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
`ifdef IFMAP_SCHED_PERF_CNT_EN
    checks++;
    if (perf !== '0) begin errors++; $display("FAIL reset_perf got %0d exp 0", perf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (vld !== 1'b0) begin errors++; $display("FAIL reset_release_vld got %b exp 0", vld); end
  endtask

  // N=8 B=1 P=1, write ready in cycle 5.
  task automatic test_single_pass();
    logic [5:0] obs, exp;
    logic [W-1:0] ea;
    do_reset();
    cfg_n = 8; cfg_b = 1; cfg_p = 1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      config_done = (c == 0);
      wr_rdy      = (c == 5);
      #1;
      exp = {c == 6, 1'b0, (c >= 7 && c <= 14), (c >= 8 && c <= 15), (c >= 1 && c <= 14), c >= 15};
      ea  = (c >= 7 && c <= 14) ? W'(c - 7) : '0;
      obs = {rts, snwb, ren, vld, busy, done};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single_flags c=%0d got %b exp %b", c, obs, exp); end
      checks++;
      if (raddr !== ea) begin errors++; $display("FAIL single_raddr c=%0d got %0d exp %0d", c, raddr, ea); end
    end
  endtask

  // N=4 B=1 P=3; config inputs change and config_done pulses mid-run, both ignored.
  task automatic test_multi_pass();
    int rd_idx = 0;
    int rts_cnt = 0;
    logic [W-1:0] ea;
    do_reset();
    cfg_n = 4; cfg_b = 1; cfg_p = 3;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      config_done = (c == 0) || (c == 6);
      wr_rdy      = (c == 2);
      if (c == 1) begin cfg_n = 2; cfg_p = 7; end
      #1;
      rts_cnt += int'(rts);
      if (ren) begin
        ea = W'(rd_idx % 4);
        checks++;
        if (raddr !== ea) begin errors++; $display("FAIL multipass_raddr read=%0d got %0d exp %0d", rd_idx, raddr, ea); end
        rd_idx++;
      end
      checks++;
      if (done !== (c >= 16)) begin errors++; $display("FAIL multipass_done c=%0d got %b exp %b", c, done, c >= 16); end
    end
    checks++;
    if (rd_idx != 12) begin errors++; $display("FAIL multipass_reads got %0d exp 12", rd_idx); end
    checks++;
    if (rts_cnt != 1) begin errors++; $display("FAIL multipass_switches got %0d exp 1", rts_cnt); end
  endtask

  // N=4 B=3 P=1, write ready held high throughout.
  task automatic test_multi_bank();
    int rd_idx = 0;
    logic [W-1:0] ea;
    logic [1:0] obs, exp;
    do_reset();
    cfg_n = 4; cfg_b = 3; cfg_p = 1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      config_done = (c == 0);
      wr_rdy      = 1'b1;
      #1;
      obs = {rts, snwb};
      exp = {(c == 2 || c == 8 || c == 14), (c == 2 || c == 8)};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL multibank_switch c=%0d got %b exp %b", c, obs, exp); end
      if (ren) begin
        ea = W'(rd_idx % 4);
        checks++;
        if (raddr !== ea) begin errors++; $display("FAIL multibank_raddr read=%0d got %0d exp %0d", rd_idx, raddr, ea); end
        rd_idx++;
      end
      checks++;
      if (done !== (c >= 19)) begin errors++; $display("FAIL multibank_done c=%0d got %b exp %b", c, done, c >= 19); end
    end
    wr_rdy = 1'b0;
    checks++;
    if (rd_idx != 12) begin errors++; $display("FAIL multibank_reads got %0d exp 12", rd_idx); end
  endtask

  // N=4 B=1 P=1, stall two cycles while raddr=2.
  task automatic test_stall();
    logic [5:0] obs, exp;
    logic [W-1:0] ea;
    do_reset();
    cfg_n = 4; cfg_b = 1; cfg_p = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      config_done = (c == 0);
      wr_rdy      = (c == 1);
      rd_stall    = (c == 5 || c == 6);
      #1;
      exp = {c == 2, 1'b0, (c == 3 || c == 4 || c == 7 || c == 8),
             (c == 4 || c == 5 || c == 8 || c == 9), (c >= 1 && c <= 8), c >= 9};
      case (c)
        4:       ea = 1;
        5, 6, 7: ea = 2;
        8:       ea = 3;
        default: ea = 0;
      endcase
      obs = {rts, snwb, ren, vld, busy, done};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_flags c=%0d got %b exp %b", c, obs, exp); end
      checks++;
      if (raddr !== ea) begin errors++; $display("FAIL stall_raddr c=%0d got %0d exp %0d", c, raddr, ea); end
`ifdef IFMAP_SCHED_PERF_CNT_EN
      if (c == 9) begin
        checks++;
        if (perf !== W'(2)) begin errors++; $display("FAIL stall_perf got %0d exp 2", perf); end
      end
`endif
    end
    rd_stall = 1'b0;
  endtask

  // Zero config values behave as 1: one switch, one read.
  task automatic test_zero_cfg();
    logic [5:0] obs, exp;
    do_reset();
    cfg_n = 0; cfg_b = 0; cfg_p = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      config_done = (c == 0);
      wr_rdy      = (c == 1);
      #1;
      exp = {c == 2, 1'b0, c == 3, c == 4, (c >= 1 && c <= 3), c >= 4};
      obs = {rts, snwb, ren, vld, busy, done};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL zero_cfg_flags c=%0d got %b exp %b", c, obs, exp); end
    end
  endtask

  // Reset asserted mid-READ at raddr=3, then a fresh config restarts at 0.
  task automatic test_reset_mid_read();
    logic [5:0] obs;
    do_reset();
    cfg_n = 4; cfg_b = 1; cfg_p = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      rst_n       = !(c == 6 || c == 7);
      config_done = (c == 0 || c == 8);
      wr_rdy      = (c == 1 || c == 9);
      #1;
      obs = {rts, snwb, ren, vld, busy, done};
      if (c == 6) begin
        checks++;
        if (raddr !== W'(3)) begin errors++; $display("FAIL midrst_pre_raddr got %0d exp 3", raddr); end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (obs !== 6'b0) begin errors++; $display("FAIL midrst_flags c=%0d got %b exp %b", c, obs, 6'b0); end
        checks++;
        if (raddr !== '0) begin errors++; $display("FAIL midrst_raddr c=%0d got %0d exp 0", c, raddr); end
      end
      if (c == 11 || c == 12) begin
        checks++;
        if (ren !== 1'b1 || raddr !== W'(c - 11)) begin
          errors++; $display("FAIL midrst_restart c=%0d got ren=%b raddr=%0d exp ren=1 raddr=%0d", c, ren, raddr, c - 11);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; config_done = 1'b0; wr_rdy = 1'b0; rd_stall = 1'b0;
    cfg_n = '0; cfg_b = '0; cfg_p = '0;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_multi_bank();
    test_stall();
    test_zero_cfg();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
